mux_sel_sequencer: RTL and testbench

Sequential front-end for the gate-level 16:1 multiplexer.
- Latches a 16-bit word and drives it onto the mux data inputs.
- Walks the four select lines through all 16 indices and samples the mux output on each step.
- Emits the sampled bits as a serial stream under a valid/ready handshake.
- Acts as a parallel-to-serial converter built around the existing mux, which stays purely combinational between `di`/`s0..s3` and `y`.

---
 rtl/mux_sel_sequencer_if.sv | 28 ++
 rtl/mux_sel_sequencer.sv | 102 ++++++++++
 tb/tb_mux_sel_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_if.sv
// Signal bundle between the mux sequencer, the 16:1 mux and the serial consumer.
// master = sequencer side, slave = environment (mux + consumer + requester) side.
interface mux_sel_sequencer_if;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] di;
  logic        s0;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        y;
  logic        dout;
  logic [4:0]  dout_idx;
  logic        dout_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, data_in, y, out_ready,
    output di, s0, s1, s2, s3, dout, dout_idx, dout_valid, busy, done
  );

  modport slave (
    output start, data_in, y, out_ready,
    input  di, s0, s1, s2, s3, dout, dout_idx, dout_valid, busy, done
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front-end that walks the 16:1 mux selects and streams y out.
// MUX_SEQ_PARITY_EN: when defined, an even-parity bit (dout_idx=16) closes each frame.
//
// state | meaning
// IDLE  | waiting for start; di holds the last accepted word
// SCAN  | stepping k through 0..15, capturing y on each handshake slot
// PAR   | presenting the parity bit (parity build only)
// DRAIN | last bit on dout, waiting for the consumer to take it
module mux_sel_sequencer (
  input logic              clk,
  input logic              rst_n,
  mux_sel_sequencer_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
`ifdef MUX_SEQ_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [3:0]  k;
  logic [15:0] di_q;
  logic        dout_q;
  logic [4:0]  idx_q;
  logic        valid_q;
  logic        done_q;
  logic        capture;

  // A new bit may be loaded when the output slot is empty or being drained this cycle.
  assign capture = !valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= 4'd0;
      di_q    <= 16'd0;
      dout_q  <= 1'b0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            di_q  <= bus.data_in;
            k     <= 4'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (capture) begin
            dout_q  <= bus.y;
            idx_q   <= {1'b0, k};
            valid_q <= 1'b1;
            k       <= k + 4'd1;
            if (k == 4'hF) begin
`ifdef MUX_SEQ_PARITY_EN
              state <= PAR;
`else
              state <= DRAIN;
`endif
            end
          end
        end
`ifdef MUX_SEQ_PARITY_EN
        PAR: begin
          if (capture) begin
            dout_q  <= ^di_q;
            idx_q   <= 5'd16;
            valid_q <= 1'b1;
            state   <= DRAIN;
          end
        end
`endif
        DRAIN: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select mapping follows the mux tree: s2/s3 pick the group, s0/s1 the leaf.
  assign bus.s2         = k[3];
  assign bus.s3         = k[2];
  assign bus.s0         = k[1];
  assign bus.s1         = k[0];
  assign bus.di         = di_q;
  assign bus.dout       = dout_q;
  assign bus.dout_idx   = idx_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: table-driven frames, random backpressure frames and reset/start corner cases.
module tb_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_sel_sequencer_if bus();

  mux_sel_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Behavioural 16:1 mux: group select {s2,s3}, leaf select {s0,s1}.
  assign bus.y = bus.di[{bus.s2, bus.s3, bus.s0, bus.s1}];

`ifdef MUX_SEQ_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam logic [16:0] BIT_MASK = (NB == 17) ? 17'h1FFFF : 17'h0FFFF;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    int          stall_idx;
    int          stall_len;
    int          exp_cycles;
    logic [16:0] exp_bits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame: start is raised immediately (so it lands in a done cycle when chained).
  // Model: bit i of the frame is data[i] (parity = ^data); first bit appears at edge 1,
  // and the frame ends at the edge where the consumer has taken its NB-th bit.
  task automatic run_frame(input logic [15:0] data, input int stall_idx, input int stall_len,
                           input bit rnd, input bit poke, output int cycles, output logic [16:0] bits);
    logic [16:0] exp;
    int e, acc, rcount, exp_done, stalls, ks;
    bit stalled, seen, r;
    logic pd;
    logic [4:0] pidx;
    logic [3:0] psel, sel;
    exp = {^data, data};
    bits = '0; acc = 0; rcount = 0; exp_done = -1; stalls = 0;
    stalled = 0; seen = 0; cycles = 0; pd = 0; pidx = '0; psel = '0;
    bus.data_in = data;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e = 0;
    chk("busy_rise", {31'd0, bus.busy}, 1);
    chk("di_latched", {16'd0, bus.di}, {16'd0, data});
    for (int t = 0; t < 300 && !seen; t++) begin
      sel = {bus.s2, bus.s3, bus.s0, bus.s1};
      if (bus.done) begin
        seen = 1;
        cycles = e + 1;
        chk("done_edge", e, exp_done);
        chk("busy_fall", {31'd0, bus.busy}, 0);
        chk("valid_drop", {31'd0, bus.dout_valid}, 0);
      end else begin
        chk("di_stable", {16'd0, bus.di}, {16'd0, data});
        chk("busy_hi", {31'd0, bus.busy}, 1);
        if (stalled) begin
          chk("hold_dout", {31'd0, bus.dout}, {31'd0, pd});
          chk("hold_idx", {27'd0, bus.dout_idx}, {27'd0, pidx});
          chk("hold_sel", {28'd0, sel}, {28'd0, psel});
        end
        if (bus.dout_valid) begin
          chk("dout_idx", {27'd0, bus.dout_idx}, acc);
          chk("dout_bit", {31'd0, bus.dout}, {31'd0, exp[bus.dout_idx]});
          ks = (int'(bus.dout_idx) + 1) % 16;
          if (bus.dout_idx == 5'd16) ks = 0;
          chk("sel_next", {28'd0, sel}, ks);
          if (data == 16'h0040 && bus.dout_idx == 5'd5) begin
            chk("sel_map_k6", {28'd0, bus.s2, bus.s3, bus.s0, bus.s1}, 32'b0110);
            chk("y_k6", {31'd0, bus.y}, 1);
          end
        end
        if (poke && e == 5) begin
          bus.start = 1'b1;
          bus.data_in = ~data;
        end else if (poke && e == 6) begin
          bus.start = 1'b0;
        end
        if (rnd) begin
          r = ($urandom_range(0, 3) != 0);
        end else begin
          r = !(bus.dout_valid && int'(bus.dout_idx) == stall_idx && stalls < stall_len);
          if (!r) stalls++;
        end
        bus.out_ready = r;
        if (e + 1 >= 2 && r) begin
          rcount++;
          if (rcount == NB) exp_done = e + 1;
        end
        if (bus.dout_valid && r) begin
          bits[bus.dout_idx] = bus.dout;
          acc++;
        end
        stalled = bus.dout_valid && !r;
        pd = bus.dout;
        pidx = bus.dout_idx;
        psel = sel;
        @(posedge clk); #1;
        e++;
      end
    end
    chk("done_seen", {31'd0, seen}, 1);
    chk("bits_taken", acc, NB);
    bus.out_ready = 1'b1;
    bus.start = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [16:0] got;
    logic [15:0] d;
    bit found;

    vecs[0] = '{16'hA5C3, -1, 0, NB + 2,     {1'b0, 16'hA5C3}};
    vecs[1] = '{16'h0040, -1, 0, NB + 2,     {1'b1, 16'h0040}};
    vecs[2] = '{16'hFFFF,  9, 3, NB + 2 + 3, {1'b0, 16'hFFFF}};
    vecs[3] = '{16'h0000,  0, 2, NB + 2 + 2, {1'b0, 16'h0000}};
    vecs[4] = '{16'h0007, 15, 1, NB + 2 + 1, {1'b1, 16'h0007}};
    vecs[5] = '{16'h0003, -1, 0, NB + 2,     {1'b0, 16'h0003}};

    bus.start = 1'b0;
    bus.data_in = 16'h0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 0);
    chk("rst_di", {16'd0, bus.di}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_sel", {28'd0, bus.s2, bus.s3, bus.s0, bus.s1}, 0);
    chk("rst_idx", {27'd0, bus.dout_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table frames are chained: each start lands in the previous frame's done cycle.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].stall_idx, vecs[i].stall_len, 1'b0, 1'b0, cyc, got);
      chk("frame_cycles", cyc, vecs[i].exp_cycles);
      chk("frame_bits", {15'd0, got & BIT_MASK}, {15'd0, vecs[i].exp_bits & BIT_MASK});
    end

    repeat (2) @(posedge clk);
    #1;
    run_frame(16'h1234, -1, 0, 1'b0, 1'b1, cyc, got);
    chk("poke_cycles", cyc, NB + 2);
    chk("poke_bits", {15'd0, got & BIT_MASK}, {15'd0, {^16'h1234, 16'h1234} & BIT_MASK});
    @(posedge clk); #1;
    chk("poke_idle", {31'd0, bus.busy}, 0);

    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_frame(d, -1, 0, 1'b1, 1'b0, cyc, got);
      chk("rand_bits", {15'd0, got & BIT_MASK}, {15'd0, {^d, d} & BIT_MASK});
    end

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1;
    bus.data_in = 16'hBEEF;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (bus.dout_valid && bus.dout_idx == 5'd5) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reach_idx5", {31'd0, found}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_di", {16'd0, bus.di}, 0);
    chk("mid_rst_sel", {28'd0, bus.s2, bus.s3, bus.s0, bus.s1}, 0);
    chk("mid_rst_dout", {31'd0, bus.dout}, 0);
    chk("mid_rst_idx", {27'd0, bus.dout_idx}, 0);
    chk("mid_rst_valid", {31'd0, bus.dout_valid}, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_done", {31'd0, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 25; t++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {30'd0, bus.busy, bus.dout_valid}, 0);
    end

    run_frame(16'hA5C3, 3, 1, 1'b0, 1'b0, cyc, got);
    chk("recover_cycles", cyc, NB + 3);
    chk("recover_bits", {15'd0, got & BIT_MASK}, {15'd0, {1'b0, 16'hA5C3} & BIT_MASK});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
